jk_cmd_sequencer: RTL and testbench

- Upstream driver for a bank of WIDTH JK flip-flops.
- Accepts set/reset/toggle/hold commands over a valid/ready interface and buffers them in a small FIFO.
- Replays each command as single-cycle J/K pulses, separated by a mandatory dead cycle.
- Keeps a shadow model of the flop bank's expected Q.

---
 rtl/jk_cmd_sequencer.sv | 132 +++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO plus IDLE/ISSUE/GAP replay FSM driving single-cycle J/K pulses to a JK flop bank.
// Define JK_SHADOW_EN to build the Q_exp shadow register; otherwise Q_exp is tied low.
module jk_cmd_sequencer #(
  parameter int                 WIDTH  = 4,
  parameter int                 DEPTH  = 4,
  parameter int                 RPT_W  = 4,
  parameter logic [WIDTH-1:0]   INIT_Q = {WIDTH{1'b1}}
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_mask,
  input  logic [RPT_W-1:0]  cmd_rpt,
  output logic [WIDTH-1:0]  J,
  output logic [WIDTH-1:0]  K,
  output logic              busy,
  output logic [WIDTH-1:0]  Q_exp
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic [RPT_W-1:0] rpt;
  } cmd_t;

  cmd_t             fifo_mem [DEPTH];
  cmd_t             head;
  state_t           state;
  logic [1:0]       cur_op;
  logic [WIDTH-1:0] cur_mask;
  logic [RPT_W-1:0] remain;
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             empty, full_nxt, empty_nxt;
  logic             push, pop, active_nxt;

  function automatic logic [WIDTH-1:0] enc_j(input logic [1:0] op, input logic [WIDTH-1:0] mask);
    return (op == OP_SET || op == OP_TOGGLE) ? mask : '0;
  endfunction

  function automatic logic [WIDTH-1:0] enc_k(input logic [1:0] op, input logic [WIDTH-1:0] mask);
    return (op == OP_RESET || op == OP_TOGGLE) ? mask : '0;
  endfunction

  // The extra pointer MSB separates full from empty when the index bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign push       = cmd_valid & cmd_ready;
  assign pop        = (state == IDLE) & ~empty;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign wr_ptr_nxt = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_ptr_nxt = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
  assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  assign active_nxt = pop || (state == ISSUE) || (state == GAP && remain != '0);

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, mask: cmd_mask, rpt: cmd_rpt};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      J         <= '0;
      K         <= '0;
      cur_op    <= '0;
      cur_mask  <= '0;
      remain    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      cmd_ready <= ~full_nxt;
      busy      <= active_nxt | ~empty_nxt;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_op   <= head.op;
            cur_mask <= head.mask;
            remain   <= head.rpt;
            J        <= enc_j(head.op, head.mask);
            K        <= enc_k(head.op, head.mask);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          J     <= '0;
          K     <= '0;
          state <= GAP;
        end
        GAP: begin
          if (remain != '0) begin
            remain <= remain - RPT_W'(1);
            J      <= enc_j(cur_op, cur_mask);
            K      <= enc_k(cur_op, cur_mask);
            state  <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_SHADOW_EN
  logic [WIDTH-1:0] q_shadow;

  // J/K registers hold exactly the encoded drive during ISSUE, so apply the JK equation to them.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)              q_shadow <= INIT_Q;
    else if (state == ISSUE) q_shadow <= (J & ~q_shadow) | (~K & q_shadow);
  end

  assign Q_exp = q_shadow;
`else
  // INIT_Q only has meaning when the shadow is built.
  assign Q_exp = INIT_Q & {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: vector table of single commands plus FIFO-full and reset-abort sequences.
module tb_jk_cmd_sequencer;

`ifdef JK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_mask = 4'b0000;
  logic [3:0] cmd_rpt = 4'd0;
  logic [3:0] J, K, Q_exp;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  jk_cmd_sequencer #(.WIDTH(4), .DEPTH(4), .RPT_W(4), .INIT_Q(4'b1111)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_rpt(cmd_rpt),
    .J(J), .K(K), .busy(busy), .Q_exp(Q_exp)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] mask;
    logic [3:0] rpt;
    logic [3:0] ej;
    logic [3:0] ek;
    logic [3:0] eq;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] seen [$];
  bit         mon_en = 1'b0;

  always @(negedge Clk) if (mon_en && (J != 4'b0 || K != 4'b0)) seen.push_back({J, K});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] qx(input logic [3:0] q);
    return SHADOW ? q : 4'b0000;
  endfunction

  // Called at a negedge with the block idle; walks every ISSUE/GAP cycle of one command.
  task automatic run_cmd(input vec_t v);
    cmd_op = v.op; cmd_mask = v.mask; cmd_rpt = v.rpt; cmd_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    cmd_valid = 1'b0;
    check("pre_issue_jk", {J, K}, 8'h00);
    check("pre_issue_busy", busy, 1'b1);
    for (int p = 0; p <= int'(v.rpt); p++) begin
      @(negedge Clk);
      check("issue_j", J, v.ej);
      check("issue_k", K, v.ek);
      @(negedge Clk);
      check("gap_jk", {J, K}, 8'h00);
      check("gap_busy", busy, 1'b1);
    end
    @(negedge Clk);
    check("end_busy", busy, 1'b0);
    check("end_jk", {J, K}, 8'h00);
    check("end_q", Q_exp, qx(v.eq));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_wait(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] rpt,
                           output int waited, output logic [3:0] j_at_accept);
    cmd_op = op; cmd_mask = mask; cmd_rpt = rpt; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge Clk);
      waited++;
    end
    if (!cmd_ready) check("push_timeout", cmd_ready, 1'b1);
    j_at_accept = J;
    @(posedge Clk);
    @(negedge Clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    logic [3:0] ja;
    logic [7:0] exp_seen [5];
    bit         leak;

    // Reset
    repeat (3) @(negedge Clk);
    check("rst_hold_jk", {J, K}, 8'h00);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_j", J, 4'b0000);
    check("rst_k", K, 4'b0000);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_q", Q_exp, qx(4'b1111));

    // Single commands, Q_exp accumulates from 1111
    vecs[0] = '{2'b10, 4'b0101, 4'd0, 4'b0000, 4'b0101, 4'b1010};
    vecs[1] = '{2'b11, 4'b0001, 4'd3, 4'b0001, 4'b0001, 4'b1010};
    vecs[2] = '{2'b01, 4'b0100, 4'd0, 4'b0100, 4'b0000, 4'b1110};
    vecs[3] = '{2'b11, 4'b0110, 4'd0, 4'b0110, 4'b0110, 4'b1000};
    vecs[4] = '{2'b00, 4'b1111, 4'd1, 4'b0000, 4'b0000, 4'b1000};
    vecs[5] = '{2'b10, 4'b0000, 4'd0, 4'b0000, 4'b0000, 4'b1000};
    vecs[6] = '{2'b11, 4'b1111, 4'd2, 4'b1111, 4'b1111, 4'b0111};
    vecs[7] = '{2'b01, 4'b1000, 4'd0, 4'b1000, 4'b0000, 4'b1111};
    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Fill FIFO behind a long mask-0 command; fifth push must wait for a pop
    mon_en = 1'b1;
    push_wait(2'b11, 4'b0000, 4'd15, w, ja);
    push_wait(2'b01, 4'b0001, 4'd0, w, ja);
    push_wait(2'b01, 4'b0010, 4'd0, w, ja);
    push_wait(2'b10, 4'b0100, 4'd0, w, ja);
    push_wait(2'b11, 4'b1000, 4'd0, w, ja);
    check("full_ready_low", cmd_ready, 1'b0);
    push_wait(2'b01, 4'b0101, 4'd0, w, ja);
    check("fifth_waited", (w > 0), 1'b1);
    check("fifth_after_pop_j", ja, 4'b0001);
    wait_idle(300);
    mon_en = 1'b0;
    exp_seen = '{8'b0001_0000, 8'b0010_0000, 8'b0000_0100, 8'b1000_1000, 8'b0101_0000};
    check("b2b_count", seen.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seen.size()) check($sformatf("b2b_order%0d", i), seen[i], exp_seen[i]);
    check("b2b_q", Q_exp, qx(4'b0111));

    // Reset during ISSUE of a TOGGLE with two commands queued
    push_wait(2'b11, 4'b1111, 4'd2, w, ja);
    push_wait(2'b01, 4'b0001, 4'd0, w, ja);
    push_wait(2'b01, 4'b0010, 4'd0, w, ja);
    @(negedge Clk);
    check("abort_pre_j", J, 4'b1111);
    check("abort_pre_k", K, 4'b1111);
    #2 Rst_n = 1'b0;
    #1;
    check("abort_async_jk", {J, K}, 8'h00);
    check("abort_async_busy", busy, 1'b0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_q", Q_exp, qx(4'b1111));
    leak = 1'b0;
    repeat (6) begin
      if (J != 4'b0 || K != 4'b0 || busy) leak = 1'b1;
      @(negedge Clk);
    end
    check("abort_fifo_flushed", leak, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
